// File: rtl/gate_truth_table_checker_pkg.sv
// Shared definitions for the gate truth-table checker: function codes and FSM encodings.
package gate_truth_table_checker_pkg;

  // Reference function codes selected by the FUNC parameter
  localparam int unsigned GF_AND  = 0;
  localparam int unsigned GF_NAND = 1;
  localparam int unsigned GF_OR   = 2;
  localparam int unsigned GF_NOR  = 3;
  localparam int unsigned GF_XOR  = 4;
  localparam int unsigned GF_XNOR = 5;

  // Sweep FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference model: expected gate output for one input vector.
module gate_ref_model
  import gate_truth_table_checker_pkg::*;
#(
  parameter int unsigned N_IN = 2,
  parameter int unsigned FUNC = GF_AND
) (
  input  logic [N_IN-1:0] vec,
  output logic            expected_c
);

  // Reduction of the vector per function code; unknown codes expect 0
  always_comb begin
    expected_c = 1'b0;
    case (FUNC)
      GF_AND:  expected_c = &vec;
      GF_NAND: expected_c = ~&vec;
      GF_OR:   expected_c = |vec;
      GF_NOR:  expected_c = ~|vec;
      GF_XOR:  expected_c = ^vec;
      GF_XNOR: expected_c = ~^vec;
      default: expected_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Exhaustive truth-table sweep of an N_IN-input gate with mismatch scoreboard.
module gate_truth_table_checker
  import gate_truth_table_checker_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned FUNC   = GF_AND,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dut_out,
  output logic [N_IN-1:0]   dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid
);

  localparam int unsigned ERR_W = N_IN + 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_VEC = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;
  logic              ffvalid_q, ffvalid_d;
  logic              ref_c;

  gate_ref_model #(
    .N_IN (N_IN),
    .FUNC (FUNC)
  ) u_ref (
    .vec        (vec_q),
    .expected_c (ref_c)
  );

  // State and scoreboard registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  // Next-state and next-output logic for the sweep
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          vec_d     = '0;
          cnt_d     = CNT_LOAD;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (dut_out != ref_c) begin
          err_d = err_q + ERR_W'(1);
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dut_in           = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench: checkers wrapped around a NAND-built AND gate and a behavioural XOR gate.
module tb_gate_truth_table_checker;
  import gate_truth_table_checker_pkg::*;

  logic clk;
  logic rst;
  logic start_and, start_nand, start_xor;
  logic [1:0] fault;   // 0 healthy, 1 stuck-at-0, 2 inverted
  logic fault_x;       // invert XOR gate output
  logic cur_sel;       // 0 AND-checker, 1 NAND-checker

  int n_vec;
  int n_err;

  // AND-reference checker
  logic [1:0] and_in;
  logic and_out, and_busy, and_done, and_pass, and_ffvalid;
  logic [2:0] and_err;
  logic [1:0] and_ffv;
  // NAND-reference checker
  logic [1:0] nand_in;
  logic nand_out, nand_busy, nand_done, nand_pass, nand_ffvalid;
  logic [2:0] nand_err;
  logic [1:0] nand_ffv;
  // XOR-reference checker
  logic [2:0] xor_in;
  logic xor_out, xor_busy, xor_done, xor_pass, xor_ffvalid;
  logic [3:0] xor_err;
  logic [2:0] xor_ffv;

  function automatic logic apply_fault(input logic g, input logic [1:0] f);
    case (f)
      2'd1:    return 1'b0;
      2'd2:    return ~g;
      default: return g;
    endcase
  endfunction

  // AND gate built from two NAND stages (x = MSB)
  logic and_n1, and_g, nand_n1, nand_g, xor_g;
  assign and_n1   = ~(and_in[1] & and_in[0]);
  assign and_g    = ~(and_n1 & and_n1);
  assign and_out  = apply_fault(and_g, fault);
  assign nand_n1  = ~(nand_in[1] & nand_in[0]);
  assign nand_g   = ~(nand_n1 & nand_n1);
  assign nand_out = apply_fault(nand_g, fault);
  assign xor_g    = ^xor_in;
  assign xor_out  = fault_x ? ~xor_g : xor_g;

  gate_truth_table_checker #(.N_IN(2), .FUNC(GF_AND), .SETTLE(2)) u_and (
    .clk(clk), .rst(rst), .start(start_and), .dut_out(and_out), .dut_in(and_in),
    .busy(and_busy), .done(and_done), .pass(and_pass), .err_count(and_err),
    .first_fail_vec(and_ffv), .first_fail_valid(and_ffvalid));

  gate_truth_table_checker #(.N_IN(2), .FUNC(GF_NAND), .SETTLE(2)) u_nand (
    .clk(clk), .rst(rst), .start(start_nand), .dut_out(nand_out), .dut_in(nand_in),
    .busy(nand_busy), .done(nand_done), .pass(nand_pass), .err_count(nand_err),
    .first_fail_vec(nand_ffv), .first_fail_valid(nand_ffvalid));

  gate_truth_table_checker #(.N_IN(3), .FUNC(GF_XOR), .SETTLE(1)) u_xor (
    .clk(clk), .rst(rst), .start(start_xor), .dut_out(xor_out), .dut_in(xor_in),
    .busy(xor_busy), .done(xor_done), .pass(xor_pass), .err_count(xor_err),
    .first_fail_vec(xor_ffv), .first_fail_valid(xor_ffvalid));

  // View of whichever 2-input checker is under test
  logic [1:0] s_in, s_ffv;
  logic [2:0] s_err;
  logic s_busy, s_done, s_pass, s_ffvalid;
  assign s_in      = cur_sel ? nand_in      : and_in;
  assign s_ffv     = cur_sel ? nand_ffv     : and_ffv;
  assign s_err     = cur_sel ? nand_err     : and_err;
  assign s_busy    = cur_sel ? nand_busy    : and_busy;
  assign s_done    = cur_sel ? nand_done    : and_done;
  assign s_pass    = cur_sel ? nand_pass    : and_pass;
  assign s_ffvalid = cur_sel ? nand_ffvalid : and_ffvalid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [1:0] flt;
    logic [2:0] err;
    logic       pass;
    logic [1:0] ffv;
    logic       ffvalid;
  } case_t;

  case_t cases [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic sel);
    if (sel) start_nand = 1'b1;
    else     start_and  = 1'b1;
    tick();
    start_and  = 1'b0;
    start_nand = 1'b0;
  endtask

  // Full 2-input sweep: per-cycle vector/busy check, then final results
  task automatic run_sweep2(input case_t c);
    logic [1:0] ev;
    cur_sel = c.sel;
    fault   = c.flt;
    pulse_start(c.sel);
    for (int cyc = 0; cyc < 12; cyc++) begin
      ev = 2'(cyc / 3);
      check("sweep busy/done/dut_in", 32'({s_busy, s_done, s_in}), 32'({1'b1, 1'b0, ev}));
      tick();
    end
    check("end busy/done/dut_in", 32'({s_busy, s_done, s_in}), 32'({1'b0, 1'b1, 2'b11}));
    check("end err_count", 32'(s_err), 32'(c.err));
    check("end pass", 32'(s_pass), 32'(c.pass));
    check("end first_fail", 32'({s_ffvalid, s_ffv}), 32'({c.ffvalid, c.ffv}));
  endtask

  // 3-input XOR sweep, SETTLE=1: two cycles per vector
  task automatic run_xor(input logic inv, input logic [3:0] e_err, input logic e_pass,
                         input logic e_ffvalid);
    logic [2:0] ev;
    fault_x   = inv;
    start_xor = 1'b1;
    tick();
    start_xor = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      ev = 3'(cyc / 2);
      check("xor busy/dut_in", 32'({xor_busy, xor_done, xor_in}), 32'({1'b1, 1'b0, ev}));
      tick();
    end
    check("xor end busy/done", 32'({xor_busy, xor_done, xor_in}), 32'({1'b0, 1'b1, 3'b111}));
    check("xor err_count", 32'(xor_err), 32'(e_err));
    check("xor pass", 32'(xor_pass), 32'(e_pass));
    check("xor first_fail", 32'({xor_ffvalid, xor_ffv}), 32'({e_ffvalid, 3'b000}));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    start_and = 1'b0; start_nand = 1'b0; start_xor = 1'b0;
    fault = 2'd0; fault_x = 1'b0; cur_sel = 1'b0;

    //                     sel   fault err   pass  ffv    ffvalid
    cases[0] = '{1'b0, 2'd0, 3'd0, 1'b1, 2'b00, 1'b0}; // AND ref, healthy
    cases[1] = '{1'b1, 2'd0, 3'd4, 1'b0, 2'b00, 1'b1}; // NAND ref vs AND gate
    cases[2] = '{1'b0, 2'd1, 3'd1, 1'b0, 2'b11, 1'b1}; // AND ref, stuck-at-0
    cases[3] = '{1'b0, 2'd2, 3'd4, 1'b0, 2'b00, 1'b1}; // AND ref, inverted gate
    cases[4] = '{1'b1, 2'd2, 3'd0, 1'b1, 2'b00, 1'b0}; // NAND ref, inverted gate
    cases[5] = '{1'b1, 2'd1, 3'd3, 1'b0, 2'b00, 1'b1}; // NAND ref, stuck-at-0

    #12;
    check("reset and outputs", 32'({and_in, and_busy, and_done, and_pass, and_err, and_ffv, and_ffvalid}), 32'd0);
    check("reset nand outputs", 32'({nand_in, nand_busy, nand_done, nand_pass, nand_err, nand_ffv, nand_ffvalid}), 32'd0);
    check("reset xor outputs", 32'({xor_in, xor_busy, xor_done, xor_pass, xor_err, xor_ffv, xor_ffvalid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_sweep2(cases[i]);

    // Async reset during vector 10, then a clean sweep
    cur_sel = 1'b0;
    fault   = 2'd2;
    pulse_start(1'b0);
    repeat (7) tick();
    check("pre-reset dut_in", 32'({and_busy, and_in}), 32'({1'b1, 2'b10}));
    #3 rst = 1'b1;
    #1;
    check("mid-sweep reset outputs", 32'({and_in, and_busy, and_done, and_pass, and_err, and_ffv, and_ffvalid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep2(cases[0]);

    // Start while busy is ignored; start after done restarts cleanly
    cur_sel = 1'b0;
    fault   = 2'd2;
    pulse_start(1'b0);
    repeat (4) tick();
    start_and = 1'b1;
    tick();
    start_and = 1'b0;
    check("re-pulse ignored", 32'({and_busy, and_in}), 32'({1'b1, 2'b01}));
    repeat (6) tick();
    check("busy at cycle 11", 32'({and_busy, and_done}), 32'({1'b1, 1'b0}));
    tick();
    check("done at cycle 12", 32'({and_busy, and_done, and_err}), 32'({1'b0, 1'b1, 3'd4}));
    fault = 2'd0;
    pulse_start(1'b0);
    check("restart clears", 32'({and_busy, and_done, and_pass, and_err, and_ffvalid, and_in}),
          32'({1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'b00}));
    repeat (11) tick();
    check("restart still busy", 32'({and_busy, and_done}), 32'({1'b1, 1'b0}));
    tick();
    check("restart result", 32'({and_busy, and_done, and_pass, and_err}), 32'({1'b0, 1'b1, 1'b1, 3'd0}));

    // 3-input XOR checker
    run_xor(1'b0, 4'd0, 1'b1, 1'b0);
    run_xor(1'b1, 4'd8, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
